vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_test_pattern.sv | 18 +
 rtl/vga_sync_gen.sv | 138 +++++++++++++
 tb/tb_vga_sync_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, counter width and colour type for the VGA sync generator.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

endpackage

// File: rtl/vga_test_pattern.sv
// Eight vertical colour bars, 80 pixels wide, selected purely from the horizontal count.
module vga_test_pattern
  import vga_pkg::*;
(
  input  logic [CNT_W-1:0] i_pix_x,
  output rgb12_t           o_rgb
);

  logic [2:0] w_bar;

  // Bars run white, yellow, cyan, green, magenta, red, blue, black: each
  // channel is a single inverted bit of the bar index.
  assign w_bar   = 3'(i_pix_x / CNT_W'(80));
  assign o_rgb.r = {4{~w_bar[1]}};
  assign o_rgb.g = {4{~w_bar[2]}};
  assign o_rgb.b = {4{~w_bar[0]}};

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: stage-0 counters, stage-1 sync/de, stage-2 pins (2-cycle latency).
// Define VGA_SYNC_TEST_PATTERN_EN to replace rgb_in with an internal colour-bar pattern.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             CLK25MHZ,
  input  logic             ck_rst,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_de,
  output logic             frame_start,
  input  logic [11:0]      rgb_in,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             vga_hs,
  output logic             vga_vs
);

  localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(FRAME_LINES - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic             r_started;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             r_de0;
  logic             r_fs0;
  logic             r_de1;
  logic             r_hs1;
  logic             r_vs1;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  rgb12_t           w_col;

  // The first cycle out of reset holds the counters at 0 so that stage 0
  // presents (0,0) together with frame_start.
  always_comb begin
    w_h_next = '0;
    w_v_next = '0;
    if (r_started) begin
      if (r_h == H_LAST) begin
        w_h_next = '0;
        w_v_next = (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
      end else begin
        w_h_next = r_h + CNT_W'(1);
        w_v_next = r_v;
      end
    end
  end

  always_ff @(posedge CLK25MHZ) begin
    if (ck_rst) begin
      r_started <= 1'b0;
      r_h       <= '0;
      r_v       <= '0;
      r_de0     <= 1'b0;
      r_fs0     <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_h       <= w_h_next;
      r_v       <= w_v_next;
      r_de0     <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
      r_fs0     <= (w_h_next == '0) && (w_v_next == '0);
    end
  end

  assign pix_x       = r_h;
  assign pix_y       = r_v;
  assign pix_de      = r_de0;
  assign frame_start = r_fs0;

  always_ff @(posedge CLK25MHZ) begin
    if (ck_rst) begin
      r_de1 <= 1'b0;
      r_hs1 <= 1'b0;
      r_vs1 <= 1'b0;
    end else begin
      r_de1 <= r_de0;
      r_hs1 <= (r_h >= HS_FIRST) && (r_h <= HS_LAST);
      r_vs1 <= (r_v >= VS_FIRST) && (r_v <= VS_LAST);
    end
  end

`ifdef VGA_SYNC_TEST_PATTERN_EN
  rgb12_t w_pat;
  rgb12_t r_pat1;

  vga_test_pattern u_pattern (
    .i_pix_x (r_h),
    .o_rgb   (w_pat)
  );

  // Registered into stage 1 so the pattern lines up with the consumer's rgb_in slot.
  always_ff @(posedge CLK25MHZ) begin
    if (ck_rst) r_pat1 <= '0;
    else        r_pat1 <= w_pat;
  end

  assign w_col = r_pat1;
`else
  assign w_col = rgb_in;
`endif

  always_ff @(posedge CLK25MHZ) begin
    if (ck_rst) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_hs <= ~r_hs1;
      vga_vs <= ~r_vs1;
      vga_r  <= r_de1 ? w_col.r : 4'h0;
      vga_g  <= r_de1 ? w_col.g : 4'h0;
      vga_b  <= r_de1 ? w_col.b : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: expected items are queued by cycle, a negedge monitor pops them.
// Vertical timing is shortened (28 lines/frame) so two full frames fit in a short run.
module tb_vga_sync_gen;

  localparam int HT = 800;
  localparam int VT = 28;
  localparam int F  = HT * VT;

  logic        clk = 1'b0;
  logic        ck_rst = 1'b1;
  logic [11:0] rgb_in = 12'hABC;
  logic [9:0]  pix_x, pix_y;
  logic        pix_de, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;

  vga_sync_gen #(
    .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
    .V_ACTIVE (20),  .V_FP (3),  .V_SYNC (2),  .V_BP (3)
  ) dut (
    .CLK25MHZ    (clk),
    .ck_rst      (ck_rst),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_de      (pix_de),
    .frame_start (frame_start),
    .rgb_in      (rgb_in),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          pins;
    int          x;
    int          y;
    bit          de;
    bit          fs;
    bit          hs;
    bit          vs;
    logic [11:0] rgb;
    string       name;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic int at(int b, int x, int y);
    return b + y * HT + x;
  endfunction

  task automatic exp_s0(int t, int x, int y, bit de, bit fs, string name);
    item_t it;
    it.at = t; it.pins = 1'b0; it.x = x; it.y = y; it.de = de; it.fs = fs;
    it.hs = 1'b1; it.vs = 1'b1; it.rgb = 12'h000; it.name = name;
    q.push_back(it);
  endtask

  task automatic exp_pin(int t, bit hs, bit vs, logic [11:0] c_def, logic [11:0] c_pat, string name);
    item_t it;
    it.at = t; it.pins = 1'b1; it.x = 0; it.y = 0; it.de = 1'b0; it.fs = 1'b0;
    it.hs = hs; it.vs = vs; it.name = name;
`ifdef VGA_SYNC_TEST_PATTERN_EN
    it.rgb = c_pat;
`else
    it.rgb = c_def;
`endif
    q.push_back(it);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Consumer model: colour for the pixel shown in one cycle arrives the next cycle.
  // Line 1 returns a position-dependent colour, every other line returns ABC.
  initial begin
    logic [9:0] sx, sy;
    forever begin
      @(negedge clk);
      sx = pix_x;
      sy = pix_y;
      @(posedge clk);
      #1;
      rgb_in = (sy == 10'd1) ? {sx[3:0], sx[7:4], ~sx[3:0]} : 12'hABC;
    end
  end

  int hs_run = 0;
  int vs_run = 0;
  int fs_last = -1;

  always @(negedge clk) begin : monitor
    int i;
    item_t it;
    i = 0;
    while (i < q.size()) begin
      if (q[i].at == cyc) begin
        it = q[i];
        q.delete(i);
        checks++;
        if (!it.pins) begin
          if (pix_x !== 10'(it.x) || pix_y !== 10'(it.y) || pix_de !== it.de || frame_start !== it.fs) begin
            errors++;
            $display("FAIL %s cyc=%0d: got x=%0d y=%0d de=%0b fs=%0b, want x=%0d y=%0d de=%0b fs=%0b",
                     it.name, cyc, pix_x, pix_y, pix_de, frame_start, it.x, it.y, it.de, it.fs);
          end else begin
            $display("ok   %s cyc=%0d x=%0d y=%0d de=%0b fs=%0b", it.name, cyc, pix_x, pix_y, pix_de, frame_start);
          end
        end else begin
          if (vga_hs !== it.hs || vga_vs !== it.vs || {vga_r, vga_g, vga_b} !== it.rgb) begin
            errors++;
            $display("FAIL %s cyc=%0d: got hs=%0b vs=%0b rgb=%h, want hs=%0b vs=%0b rgb=%h",
                     it.name, cyc, vga_hs, vga_vs, {vga_r, vga_g, vga_b}, it.hs, it.vs, it.rgb);
          end else begin
            $display("ok   %s cyc=%0d hs=%0b vs=%0b rgb=%h", it.name, cyc, vga_hs, vga_vs, {vga_r, vga_g, vga_b});
          end
        end
      end else begin
        i++;
      end
    end

    if (ck_rst) begin
      hs_run  = 0;
      vs_run  = 0;
      fs_last = -1;
    end else begin
      if (!vga_hs) hs_run++;
      else if (hs_run != 0) begin
        checks++;
        if (hs_run != 96) begin
          errors++;
          $display("FAIL hs_width cyc=%0d: got %0d cycles low, want 96", cyc, hs_run);
        end
        hs_run = 0;
      end
      if (!vga_vs) vs_run++;
      else if (vs_run != 0) begin
        checks++;
        if (vs_run != 1600) begin
          errors++;
          $display("FAIL vs_width cyc=%0d: got %0d cycles low, want 1600", cyc, vs_run);
        end
        vs_run = 0;
      end
      if (frame_start) begin
        if (fs_last >= 0) begin
          checks++;
          if (cyc - fs_last != F) begin
            errors++;
            $display("FAIL fs_period cyc=%0d: got %0d cycles, want %0d", cyc, cyc - fs_last, F);
          end else begin
            $display("ok   fs_period cyc=%0d period=%0d", cyc, cyc - fs_last);
          end
        end
        fs_last = cyc;
      end
    end
  end

  initial begin
    int b0, b1, c, c_end;
    b0    = 6;                        // first stage-0 cycle after releasing reset at cycle 5
    c     = at(b0, 300, 10) + 2 * F;  // mid-frame reset point in frame 3
    b1    = c + 2;
    c_end = b1 + 900;

    exp_s0 (3, 0, 0, 0, 0, "rst_s0");
    exp_pin(3, 1, 1, 12'h000, 12'h000, "rst_pins");

    exp_s0 (at(b0, 0, 0),    0,   0, 1, 1, "first_s0");
    exp_s0 (at(b0, 1, 0),    1,   0, 1, 0, "x1_s0");
    exp_s0 (at(b0, 640, 0),  640, 0, 0, 0, "x640_s0");
    exp_s0 (at(b0, 639, 19), 639, 19, 1, 0, "last_vis_s0");
    exp_s0 (at(b0, 0, 20),   0,   20, 0, 0, "y20_s0");
    exp_s0 (at(b0, 799, 27), 799, 27, 0, 0, "frame_end_s0");
    exp_s0 (at(b0, 0, 0) + F, 0,  0, 1, 1, "frame2_s0");

    exp_pin(at(b0, 0, 0) + 2,   1, 1, 12'hABC, 12'hFFF, "pin_x0");
    exp_pin(at(b0, 79, 0) + 2,  1, 1, 12'hABC, 12'hFFF, "pin_x79");
    exp_pin(at(b0, 80, 0) + 2,  1, 1, 12'hABC, 12'hFF0, "pin_x80");
    exp_pin(at(b0, 639, 0) + 2, 1, 1, 12'hABC, 12'h000, "pin_x639");
    exp_pin(at(b0, 640, 0) + 2, 1, 1, 12'h000, 12'h000, "pin_x640");
    exp_pin(at(b0, 655, 0) + 2, 1, 1, 12'h000, 12'h000, "hs_x655");
    exp_pin(at(b0, 656, 0) + 2, 0, 1, 12'h000, 12'h000, "hs_x656");
    exp_pin(at(b0, 751, 0) + 2, 0, 1, 12'h000, 12'h000, "hs_x751");
    exp_pin(at(b0, 752, 0) + 2, 1, 1, 12'h000, 12'h000, "hs_x752");
    exp_pin(at(b0, 5, 1) + 2,   1, 1, 12'h50A, 12'hFFF, "col_x5");
    exp_pin(at(b0, 300, 1) + 2, 1, 1, 12'hC23, 12'h0F0, "col_x300");
    exp_pin(at(b0, 639, 1) + 2, 1, 1, 12'hF70, 12'h000, "col_x639");
    exp_pin(at(b0, 799, 5) + 2, 1, 1, 12'h000, 12'h000, "hblank_x799");
    exp_pin(at(b0, 0, 20) + 2,  1, 1, 12'h000, 12'h000, "vblank_y20");
    exp_pin(at(b0, 799, 22) + 2, 1, 1, 12'h000, 12'h000, "vs_before");
    exp_pin(at(b0, 0, 23) + 2,  1, 0, 12'h000, 12'h000, "vs_start");
    exp_pin(at(b0, 799, 24) + 2, 1, 0, 12'h000, 12'h000, "vs_last");
    exp_pin(at(b0, 0, 25) + 2,  1, 1, 12'h000, 12'h000, "vs_after");
    exp_pin(at(b0, 0, 0) + F + 2, 1, 1, 12'hABC, 12'hFFF, "frame2_pin");

    exp_s0 (c,     300, 10, 1, 0, "pre_rst_s0");
    exp_s0 (c + 1, 0,   0,  0, 0, "mid_rst_s0");
    exp_pin(c + 1, 1, 1, 12'h000, 12'h000, "mid_rst_pins");
    exp_s0 (b1,    0,   0,  1, 1, "restart_s0");
    exp_pin(b1,     1, 1, 12'h000, 12'h000, "restart_pin0");
    exp_pin(b1 + 1, 1, 1, 12'h000, 12'h000, "restart_pin1");
    exp_pin(b1 + 2, 1, 1, 12'hABC, 12'hFFF, "restart_pin2");
    exp_pin(at(b1, 655, 0) + 2, 1, 1, 12'h000, 12'h000, "restart_hs655");
    exp_pin(at(b1, 656, 0) + 2, 0, 1, 12'h000, 12'h000, "restart_hs656");

    wait_cyc(5);
    ck_rst = 1'b0;
    wait_cyc(c);
    ck_rst = 1'b1;
    wait_cyc(c + 1);
    ck_rst = 1'b0;
    wait_cyc(c_end);
    @(negedge clk);

    foreach (q[k]) begin
      checks++;
      errors++;
      $display("FAIL %s: never observed, due at cycle %0d", q[k].name, q[k].at);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
